// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: greedy coin-return sequencer (dollar, quarter, dime) over a req/ack hopper handshake
// with per-denomination inventory and shortfall/timeout reporting.
module change_dispense_ctrl #(
    parameter int AMT_W       = 10,
    parameter int DOLLAR_VAL  = 100,
    parameter int QUARTER_VAL = 25,
    parameter int DIME_VAL    = 10,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 20,
    parameter int TIMEOUT     = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_in,
    input  logic             refill,
    input  logic             coin_ack,
    output logic             coin_req,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] shortfall
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SELECT, REQ, FIN} state_t;
    state_t           state;
    logic [INV_W-1:0] inv_dollar, inv_quarter, inv_dime;
    logic [CNT_W-1:0] tmo_cnt;
    logic             can_dollar, can_quarter, can_dime;
    logic [AMT_W-1:0] coin_val;
    always_comb begin
        can_dollar  = inv_dollar  != '0 && remaining >= AMT_W'(DOLLAR_VAL);
        can_quarter = inv_quarter != '0 && remaining >= AMT_W'(QUARTER_VAL);
        can_dime    = inv_dime    != '0 && remaining >= AMT_W'(DIME_VAL);
        coin_val    = coin_type == 2'd3 ? AMT_W'(DOLLAR_VAL) :
                      coin_type == 2'd2 ? AMT_W'(QUARTER_VAL) : AMT_W'(DIME_VAL);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            coin_req    <= 1'b0;
            coin_type   <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            remaining   <= '0;
            shortfall   <= '0;
            inv_dollar  <= INV_W'(INV_INIT);
            inv_quarter <= INV_W'(INV_INIT);
            inv_dime    <= INV_W'(INV_INIT);
            tmo_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_in;
                        error     <= 1'b0;
                        shortfall <= '0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end else if (refill) begin
                        inv_dollar  <= INV_W'(INV_INIT);
                        inv_quarter <= INV_W'(INV_INIT);
                        inv_dime    <= INV_W'(INV_INIT);
                    end
                end
                SELECT: begin
                    if (remaining == '0) begin
                        error <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (can_dollar || can_quarter || can_dime) begin
                        coin_type <= can_dollar ? 2'd3 : can_quarter ? 2'd2 : 2'd1;
                        coin_req  <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= REQ;
                    end else begin
                        error     <= 1'b1;
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                REQ: begin
                    if (coin_ack) begin
                        remaining   <= remaining - coin_val;
                        inv_dollar  <= inv_dollar  - INV_W'(coin_type == 2'd3);
                        inv_quarter <= inv_quarter - INV_W'(coin_type == 2'd2);
                        inv_dime    <= inv_dime    - INV_W'(coin_type == 2'd1);
                        coin_req    <= 1'b0;
                        coin_type   <= 2'd0;
                        state       <= SELECT;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // hopper gave up: coin never left, so inventory stays as is
                        coin_req  <= 1'b0;
                        coin_type <= 2'd0;
                        error     <= 1'b1;
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
